// File: rtl/canny_frame_capture.sv
// Single-frame capture buffer for the canny_top pixel stream, with valid/ready replay.
// Slots with in_valid low are stored as zero, so the buffer stays cycle-aligned with the input.
module canny_frame_capture #(
    parameter int unsigned IMG_W = 256,
    parameter int unsigned IMG_H = 256,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_pixel_i,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_eol_o,
    output logic          rd_last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW:0]   valid_count_o
);

    localparam int unsigned NPIX     = IMG_W * IMG_H;
    localparam int unsigned CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [AW:0]   LAST_PTR = (AW+1)'(NPIX - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READOUT
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          rd_eol_q;
    logic          rd_last_q;
    logic          busy_q;
    logic          done_q;
    logic [AW:0]   valid_count_q;

    logic [DW-1:0] frame_q [2**AW];

    // Frame storage is never cleared; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && state_q == CAPTURE) begin
            frame_q[wptr_q] <= in_valid_i ? in_pixel_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            rptr_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_eol_q      <= 1'b0;
            rd_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q       <= CAPTURE;
                        wptr_q        <= '0;
                        valid_count_q <= '0;
                        busy_q        <= 1'b1;
                    end
                end
                CAPTURE: begin
                    wptr_q <= wptr_q + AW'(1);
                    if (in_valid_i) begin
                        valid_count_q <= valid_count_q + (AW+1)'(1);
                    end
                    if ({1'b0, wptr_q} == LAST_PTR) begin
                        state_q <= READOUT;
                        rptr_q  <= '0;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                READOUT: begin
                    if (rd_valid_q && rd_ready_i && rd_last_q) begin
                        rd_valid_q <= 1'b0;
                        rd_eol_q   <= 1'b0;
                        rd_last_q  <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (!rd_valid_q || (rd_ready_i && !rd_last_q)) begin
                        // Fetch the next beat when the output slot is empty or being drained.
                        rd_data_q  <= frame_q[rptr_q];
                        rd_valid_q <= 1'b1;
                        rd_eol_q   <= (col_q == LAST_COL);
                        rd_last_q  <= (col_q == LAST_COL) && (row_q == LAST_ROW);
                        rptr_q     <= rptr_q + AW'(1);
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign rd_eol_o      = rd_eol_q;
    assign rd_last_o     = rd_last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign valid_count_o = valid_count_q;

endmodule

// File: tb/tb_canny_frame_capture.sv
// Directed bench for canny_frame_capture on a 4x3 frame: capture, zero-fill, backpressure,
// start filtering and mid-capture reset.
module tb_canny_frame_capture;

    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int NPIX = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          in_valid_i;
    logic [DW-1:0] in_pixel_i;
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic [DW-1:0] rd_data_o;
    logic          rd_eol_o;
    logic          rd_last_o;
    logic          busy_o;
    logic          done_o;
    logic [AW:0]   valid_count_o;

    canny_frame_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .in_valid_i   (in_valid_i),
        .in_pixel_i   (in_pixel_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .rd_eol_o     (rd_eol_o),
        .rd_last_o    (rd_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .valid_count_o(valid_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] px;
        logic [7:0] exp;
        logic       eol;
        logic       last;
    } vec_t;

    vec_t pat [NPIX];
    vec_t zf  [NPIX];
    vec_t cur [NPIX];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start then the 12 capture slots from cur; optional start pulse on slot start_slot.
    task automatic do_capture(input int start_slot);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("cap_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < NPIX; i++) begin
            in_valid_i = cur[i].v;
            in_pixel_i = cur[i].px;
            start_i    = (i == start_slot);
            step();
        end
        in_valid_i = 1'b0;
        in_pixel_i = 8'h5A;
        start_i    = 1'b0;
        chk("cap_end_busy", 32'(busy_o), 32'd1);
        chk("cap_end_nvalid", 32'(rd_valid_o), 32'd0);
    endtask

    // Drains the frame against cur; bp selects the 1,0,0,1 ready pattern, st injects starts.
    task automatic do_readout(input bit bp, input bit st);
        int idx = 0;
        int k = 0;
        int guard = 0;
        int vcnt = 0;
        bit stalled = 1'b0;
        logic [7:0] pd = '0;
        logic pe = 1'b0;
        logic pl = 1'b0;
        logic rdy;
        for (int i = 0; i < NPIX; i++) vcnt += int'(cur[i].v);
        rd_ready_i = 1'b1;
        while (!rd_valid_o && guard < 20) begin
            step();
            guard++;
        end
        chk("first_valid", 32'(rd_valid_o), 32'd1);
        guard = 0;
        while (idx < NPIX && guard < 100) begin
            rdy = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            chk("valid_held", 32'(rd_valid_o), 32'd1);
            chk("no_early_done", 32'(done_o), 32'd0);
            if (stalled) begin
                chk("stall_data", 32'(rd_data_o), 32'(pd));
                chk("stall_eol", 32'(rd_eol_o), 32'(pe));
                chk("stall_last", 32'(rd_last_o), 32'(pl));
            end
            chk($sformatf("data[%0d]", idx), 32'(rd_data_o), 32'(cur[idx].exp));
            chk($sformatf("eol[%0d]", idx), 32'(rd_eol_o), 32'(cur[idx].eol));
            chk($sformatf("last[%0d]", idx), 32'(rd_last_o), 32'(cur[idx].last));
            pd = rd_data_o;
            pe = rd_eol_o;
            pl = rd_last_o;
            rd_ready_i = rdy;
            start_i = st && ((idx == 5) || (idx == NPIX - 1 && rdy == 1'b1));
            if (rdy) begin
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
            end
            k++;
            step();
            guard++;
        end
        start_i    = 1'b0;
        rd_ready_i = 1'b1;
        chk("beats", 32'(idx), 32'(NPIX));
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("done_nvalid", 32'(rd_valid_o), 32'd0);
        chk("done_nbusy", 32'(busy_o), 32'd0);
        chk("valid_count", 32'(valid_count_o), 32'(vcnt));
        step();
        chk("done_single", 32'(done_o), 32'd0);
        chk("idle_nbusy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        pat[0]  = '{1'b1, 8'h10, 8'h10, 1'b0, 1'b0};
        pat[1]  = '{1'b1, 8'h11, 8'h11, 1'b0, 1'b0};
        pat[2]  = '{1'b1, 8'h12, 8'h12, 1'b0, 1'b0};
        pat[3]  = '{1'b1, 8'h13, 8'h13, 1'b1, 1'b0};
        pat[4]  = '{1'b1, 8'h14, 8'h14, 1'b0, 1'b0};
        pat[5]  = '{1'b1, 8'h15, 8'h15, 1'b0, 1'b0};
        pat[6]  = '{1'b1, 8'h16, 8'h16, 1'b0, 1'b0};
        pat[7]  = '{1'b1, 8'h17, 8'h17, 1'b1, 1'b0};
        pat[8]  = '{1'b1, 8'h18, 8'h18, 1'b0, 1'b0};
        pat[9]  = '{1'b1, 8'h19, 8'h19, 1'b0, 1'b0};
        pat[10] = '{1'b1, 8'h1A, 8'h1A, 1'b0, 1'b0};
        pat[11] = '{1'b1, 8'h1B, 8'h1B, 1'b1, 1'b1};
        // Invalid slots carry junk pixels that must be stored as zero.
        zf[0]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
        zf[1]  = '{1'b0, 8'hAA, 8'h00, 1'b0, 1'b0};
        zf[2]  = '{1'b0, 8'h33, 8'h00, 1'b0, 1'b0};
        zf[3]  = '{1'b0, 8'hC3, 8'h00, 1'b1, 1'b0};
        zf[4]  = '{1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        zf[5]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
        zf[6]  = '{1'b0, 8'h77, 8'h00, 1'b0, 1'b0};
        zf[7]  = '{1'b0, 8'h80, 8'h00, 1'b1, 1'b0};
        zf[8]  = '{1'b0, 8'hFE, 8'h00, 1'b0, 1'b0};
        zf[9]  = '{1'b0, 8'h42, 8'h00, 1'b0, 1'b0};
        zf[10] = '{1'b0, 8'h99, 8'h00, 1'b0, 1'b0};
        zf[11] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1};

        rst        = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        in_pixel_i = '0;
        rd_ready_i = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(rd_valid_o), 32'd0);
        chk("rst_data", 32'(rd_data_o), 32'd0);
        chk("rst_eol", 32'(rd_eol_o), 32'd0);
        chk("rst_last", 32'(rd_last_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_vcount", 32'(valid_count_o), 32'd0);
        rst = 1'b1;
        step();
        step();
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Plain pattern capture, full-rate readback.
        cur = pat;
        do_capture(-1);
        do_readout(1'b0, 1'b0);

        // Zero-fill capture with 1,0,0,1 backpressure.
        cur = zf;
        do_capture(-1);
        do_readout(1'b1, 1'b0);

        // Starts during capture, readout and on the final accept are ignored.
        cur = pat;
        do_capture(2);
        do_readout(1'b0, 1'b1);

        // Start on the cycle after done begins a new capture.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("restart_busy", 32'(busy_o), 32'd1);
        chk("restart_vcount", 32'(valid_count_o), 32'd0);

        // Reset at capture slot 6 aborts without a done pulse.
        for (int i = 0; i < 6; i++) begin
            in_valid_i = 1'b1;
            in_pixel_i = 8'hE0 + 8'(i);
            step();
        end
        rst = 1'b0;
        step();
        rst        = 1'b1;
        in_valid_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_valid", 32'(rd_valid_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_vcount", 32'(valid_count_o), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("abort_idle_done", 32'(done_o), 32'd0);
            chk("abort_idle_valid", 32'(rd_valid_o), 32'd0);
        end
        chk("abort_idle_busy", 32'(busy_o), 32'd0);

        cur = zf;
        do_capture(-1);
        do_readout(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
